// File: rtl/dmem_responder_pkg.sv
// MMIO address map, funct3 encodings and STATUS register layout for the data-memory responder.
package Dmem_Map_PKG;

    localparam logic [7:0] CONSOLE_TX = 8'h00;
    localparam logic [7:0] STATUS     = 8'h04;
    localparam logic [7:0] CYCLE      = 8'h08;
    localparam logic [7:0] ERR_ADDR   = 8'h0C;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_MIS     = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_COUNT   = 4;
    localparam int ST_COUNT_W = 4;

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO feeding the console TX port; a pop frees a slot for a push in the same cycle.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: 256-byte lane RAM with sized/extended accesses plus an MMIO window
// holding the console TX FIFO, a cycle counter and sticky misalignment/overflow status.
module dmem_responder
    import Dmem_Map_PKG::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] rd_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              is_mmio;
    logic [7:0]        offset;
    logic [5:0]        word_idx;
    logic [1:0]        lane;
    logic              half_acc, word_acc, misaligned;
    logic              store_ok, load_ok;
    logic [3:0]        lane_we;
    logic [3:0][7:0]   lane_wd;
    logic [3:0][7:0]   ram_q [64];
    logic [3:0][7:0]   ram_word;
    logic [7:0]        ram_byte;
    logic [15:0]       ram_half;
    logic [DATA_W-1:0] ram_rd, mmio_rd, status_word;
    logic              push, status_wr, ovf_set;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic [DATA_W-1:0] cycle_q, cycle_d;
    logic              mis_q, mis_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    assign is_mmio  = addr[ADDR_W-1];
    assign offset   = addr[7:0];
    assign word_idx = addr[7:2];
    assign lane     = addr[1:0];

    // A concurrent read+write is treated as a store, so only the store encodings decide its alignment.
    always_comb begin
        half_acc = 1'b0;
        if (MemWrite)     half_acc = (funct3 == F3_H);
        else if (MemRead) half_acc = (funct3 == F3_H) || (funct3 == F3_HU);
        word_acc   = (MemRead || MemWrite) && (funct3 == F3_W);
        misaligned = (half_acc && addr[0]) || (word_acc && (lane != 2'b00));
    end

    assign store_ok = MemWrite && !misaligned;
    assign load_ok  = MemRead && !MemWrite && !misaligned;

    always_comb begin
        lane_we = '0;
        lane_wd = wr_data[31:0];
        if (store_ok && !is_mmio && !reset) begin
            case (funct3)
                F3_B: begin
                    lane_we[lane] = 1'b1;
                    lane_wd       = {4{wr_data[7:0]}};
                end
                F3_H: begin
                    lane_we[{lane[1], 1'b0}] = 1'b1;
                    lane_we[{lane[1], 1'b1}] = 1'b1;
                    lane_wd                  = {2{wr_data[15:0]}};
                end
                F3_W:    lane_we = 4'hF;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (lane_we[l]) ram_q[word_idx][l] <= lane_wd[l];
        end
    end

    always_comb begin
        ram_word = ram_q[word_idx];
        ram_byte = ram_word[lane];
        ram_half = lane[1] ? ram_word[3:2] : ram_word[1:0];
        case (funct3)
            F3_B:    ram_rd = {{24{ram_byte[7]}}, ram_byte};
            F3_BU:   ram_rd = {24'b0, ram_byte};
            F3_H:    ram_rd = {{16{ram_half[15]}}, ram_half};
            F3_HU:   ram_rd = {16'b0, ram_half};
            F3_W:    ram_rd = ram_word;
            default: ram_rd = '0;
        endcase
    end

    always_comb begin
        status_word                           = '0;
        status_word[ST_FULL]                  = fifo_full;
        status_word[ST_EMPTY]                 = fifo_empty;
        status_word[ST_MIS]                   = mis_q;
        status_word[ST_OVF]                   = ovf_q;
        status_word[ST_COUNT +: ST_COUNT_W]   = ST_COUNT_W'(fifo_count);
        case (offset)
            STATUS:   mmio_rd = status_word;
            CYCLE:    mmio_rd = cycle_q;
            ERR_ADDR: mmio_rd = DATA_W'(err_addr_q);
            default:  mmio_rd = '0;
        endcase
        rd_data = '0;
        if (load_ok) rd_data = is_mmio ? mmio_rd : ram_rd;
    end

    assign push      = store_ok && is_mmio && (offset == CONSOLE_TX);
    assign status_wr = store_ok && is_mmio && (offset == STATUS);
    assign ovf_set   = push && fifo_full && !tx_ready;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (wr_data[7:0]),
        .pop       (tx_ready),
        .pop_data  (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid = !fifo_empty;
    assign err      = mis_q || ovf_q;

    // Clears are applied before sets so a coincident set event wins.
    always_comb begin
        cycle_d    = cycle_q + DATA_W'(1);
        mis_d      = mis_q;
        ovf_d      = ovf_q;
        err_addr_d = err_addr_q;
        if (status_wr && wr_data[ST_MIS]) mis_d = 1'b0;
        if (status_wr && wr_data[ST_OVF]) ovf_d = 1'b0;
        if (misaligned) begin
            mis_d = 1'b1;
            if (!mis_q) err_addr_d = addr;
        end
        if (ovf_set) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q    <= '0;
            mis_q      <= 1'b0;
            ovf_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            cycle_q    <= cycle_d;
            mis_q      <= mis_d;
            ovf_q      <= ovf_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule
